// File: rtl/seg7_if.sv
// Display-side bundle for seg7_scan_driver: nibble value, load strobe, digit enables
// and the registered anode/cathode/busy outputs.
interface seg7_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy;

  modport master (output value, load, digit_en, input an, seg, busy);
  modport slave  (input value, load, digit_en, output an, seg, busy);
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with shadow capture and
// anti-ghosting blank window. Optional macro: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned DIV_W        = 17
) (
  input logic   clk,
  input logic   rst_n,
  seg7_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [6:0]       SEG_OFF   = 7'b1111111;
  localparam logic [3:0]       AN_OFF    = 4'b1111;

  typedef enum logic {BLANK, SHOW} slot_t;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             busy_q;

  slot_t      phase_c;
  logic       tick_c;
  logic [3:0] nib_c;
  logic       lz_c;
  logic       show_c;
  logic [3:0] an_nxt_c;
  logic [6:0] seg_nxt_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next output image from the current slot position and shadow contents
  always_comb begin
    phase_c   = (div < BLANK_END) ? BLANK : SHOW;
    tick_c    = (div == DIV_LAST);
    nib_c     = shadow[{idx, 2'b00} +: 4];
    lz_c      = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (idx)
      2'd1:    lz_c = (shadow[15:4]  == 12'h000);
      2'd2:    lz_c = (shadow[15:8]  == 8'h00);
      2'd3:    lz_c = (shadow[15:12] == 4'h0);
      default: lz_c = 1'b0;
    endcase
`endif
    show_c    = bus.digit_en[idx] && !lz_c;
    an_nxt_c  = AN_OFF;
    seg_nxt_c = SEG_OFF;
    if (phase_c == SHOW && show_c) begin
      an_nxt_c  = ~(4'b0001 << idx);
      seg_nxt_c = hex7(nib_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      idx    <= 2'd0;
      shadow <= 16'h0000;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      busy_q <= 1'b1;
    end else begin
      div    <= tick_c ? '0 : div + DIV_W'(1);
      if (tick_c) idx <= idx + 2'd1;
      if (bus.load) shadow <= bus.value;
      an_q   <= an_nxt_c;
      seg_q  <= seg_nxt_c;
      busy_q <= (phase_c == BLANK);
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  seg7_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .DIV_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int e     = 0;          // clk edges since reset release
  logic [15:0] sh_m = '0; // expected shadow contents

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  // Expected outputs after edge number n, seen from slot position and shadow before that edge
  task automatic expect_out(input int n, output logic [3:0] ea, output logic [6:0] es,
                            output logic eb);
    int d, i;
    logic off;
    d  = (n - 1) % 8;
    i  = ((n - 1) / 8) % 4;
    ea = 4'b1111;
    es = 7'b1111111;
    eb = (d < 2);
    off = !bus.digit_en[i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i != 0 && (sh_m >> (4 * i)) == 16'h0) off = 1'b1;
`endif
    if (!eb && !off) begin
      ea = an_tab[i];
      es = hex_tab[(sh_m >> (4 * i)) & 16'hF];
    end
  endtask

  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    logic       eb;
    expect_out(e + 1, ea, es, eb);
    @(posedge clk);
    #1;
    e++;
    chk("an",   32'(bus.an),   32'(ea));
    chk("seg",  32'(bus.seg),  32'(es));
    chk("busy", 32'(bus.busy), 32'(eb));
    chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'(1));
    if (bus.load) sh_m = bus.value;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},   32'(bus.an),   32'h0000000F);
    chk({tag, "_seg"},  32'(bus.seg),  32'h0000007F);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h00000001);
  endtask

  initial begin
    int k;
    rst_n        = 1'b0;
    bus.value    = 16'h0000;
    bus.load     = 1'b0;
    bus.digit_en = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Full frame with 3210 captured on the first edge
    bus.value = 16'h3210;
    bus.load  = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (31) step();

    // Sweep nibble 0 through 0..F while slot 0 is being shown
    k = 0;
    while (k < 16) begin
      if ((e % 32) >= 1 && (e % 32) <= 6) begin
        bus.value = {12'h321, 4'(k)};
        bus.load  = 1'b1;
        k++;
      end else begin
        bus.load = 1'b0;
      end
      step();
    end
    bus.load = 1'b0;
    step();

    // Digits 1 and 3 disabled
    while ((e % 32) != 0) step();
    bus.digit_en = 4'b0101;
    bus.value    = 16'hFFFF;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (31) step();
    bus.digit_en = 4'b1111;

    // Load coincident with the tick into slot 3
    while ((e % 32) != 23) step();
    bus.value = 16'hA000;
    bus.load  = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (8) step();
    chk("slot3_an",  32'(bus.an),  32'h7);
    chk("slot3_seg", 32'(bus.seg), 32'(7'b0001000));

    // Asynchronous reset in the middle of slot 2 SHOW
    while ((e % 32) != 20) step();
    chk("pre_reset_an", 32'(bus.an), 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(posedge clk);
    #1;
    chk_reset("held_reset");
    rst_n = 1'b1;
    e     = 0;
    sh_m  = 16'h0000;
    repeat (32) step();

    // Leading-zero handling with 0050
    bus.value = 16'h0050;
    bus.load  = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (31) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the 4-bit lab counters.
- Captures up to four 4-bit nibbles, usually counter outputs, into a shadow register on a load strobe.
- Time-multiplexes the nibbles onto a common-anode 4-digit seven-segment display, with a refresh divider and anti-ghosting blanking.
- All outputs are registered and glitch-free.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. Must be at least 4.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be less than REFRESH_DIV.
- DIV_W, 17: width of the divider counter. Must satisfy 2^DIV_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  16  four nibbles. Digit d shows value[4d+3:4d]; digit 0 is rightmost.
- load  in  1  when high at a rising clk edge, value is captured into the shadow register.
- digit_en  in  4  per-digit enable, sampled live. A 0 keeps that anode off during its slot.
- an  out  4  anodes, active-low, one-hot-low or all-high.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- busy  out  1  high during the blanking window of the current slot.

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous, any cycle):
  - div=0, idx=0, shadow=16'h0000.
  - an=4'b1111, seg=7'b1111111, busy=1.
  - Release is synchronous to the next clk edge. Reset mid-slot or mid-load discards all state.
- Divider:
  - div counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (div == REFRESH_DIV-1).
  - On tick, idx advances 0→1→2→3→0 (2-bit wrap).
- Slot FSM, per slot:
  - BLANK while div < BLANK_CYCLES: an=1111, seg=1111111, busy=1.
  - SHOW otherwise: busy=0. an has bit idx low iff digit_en[idx]=1. seg = hex pattern of shadow nibble idx.
  - If digit_en[idx]=0: an=1111 and seg=1111111.
- Output timing: an, seg and busy are registered from the current div, idx, shadow and digit_en. Latency is 1 cycle.
  - load at edge k updates shadow at edge k; seg reflects the new value at edge k+1, if in SHOW.
  - tick at edge k changes idx at edge k; the new slot's BLANK appears on an at edge k+1.
- Shadow updates mid-SHOW are permitted. The segment change is immediate (1-cycle latency); no per-slot holdoff.
- load held high captures every cycle. Simultaneous load and tick: both take effect at the same edge.
- Hex encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Never more than one anode low in any cycle.
- Full frame = 4*REFRESH_DIV cycles.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - During SHOW, digit d is forced off (an bit high, seg=1111111) if d != 0 and all shadow nibbles from d up to 3 are zero.
  - Digit 0 always shows, so 0x0000 displays "0" and 0x0050 displays "50".
  - Applies on top of digit_en.
- Undefined: all enabled digits show, including leading zeros.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
1. Assert rst_n=0 mid-SHOW of slot 2 → an=1111, seg=1111111 and busy=1 asynchronously, without waiting for clk. After release, slot 0 begins with 2 blank cycles.
2. load with value=16'h3210, digit_en=1111 → over one 32-cycle frame, cycles 3-8 show an=1110/seg=1000000, then an=1101/seg=1111001, an=1011/seg=0100100, an=0111/seg=0110000. Each slot has exactly 2 blank cycles and busy matches.
3. Sweep value nibble 0 through 0..F → seg matches the 16-entry table above in slot 0.
4. digit_en=0101, value=16'hFFFF → an is 1110 and 1011 in slots 0 and 2; an=1111 for all of slots 1 and 3.
5. load value=16'hA000 on the same edge as the tick into slot 3 → slot 3 SHOW shows seg=0001000 with no stale nibble. Assert no cycle ever has more than one anode low.
6. With SEG7_LEADING_ZERO_BLANK_EN, value=16'h0050 → digits 0 and 1 show "0" and "5"; digits 2 and 3 stay an-high. Without the macro → all four show, including seg=1000000 for the zero digits.
